// File: rtl/banked_mem_ctrl.sv
// rtl/banked_mem_ctrl.sv - big-endian banked halfword memory, CPU load/store port A and fetch port B
// Optional feature macro: RDW_BYPASS_EN (forward same-edge port A store data to a colliding port B read)
module banked_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15,
    parameter int LANES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_valid_i,
    output logic              a_req_ready_o,
    input  logic              a_we_i,
    input  logic              a_half_i,
    input  logic              a_sext_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_rsp_valid_o,
    input  logic              a_rsp_ready_i,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_valid_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic              b_rsp_valid_o,
    output logic [15:0]       b_rdata_o
);

    localparam int LG   = $clog2(LANES);
    localparam int RW   = ADDR_W - LG;
    localparam int ROWS = 1 << RW;

    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    state_t state_q, state_d;

    logic              a_accept;
    logic [LG-1:0]     a_lane;
    logic [RW-1:0]     a_row;
    logic [LG-1:0]     b_lane;
    logic [RW-1:0]     b_row;

    // Per-bank write/read controls for port A
    logic [15:0]       a_wh     [LANES];
    logic [LG-1:0]     a_hsel   [LANES];
    logic [15:0]       a_wd_b   [LANES];
    logic [RW-1:0]     a_row_b  [LANES];
    logic              a_we_b   [LANES];

    // Bank read outputs
    logic [15:0]       a_dout_w [LANES];
    logic [15:0]       b_dout_w [LANES];

    // Response context captured at acceptance
    logic              we_q, half_q, sext_q, first_q;
    logic [LG-1:0]     lane_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] fmt;
    logic [DATA_W-1:0] rd_word;
    logic [15:0]       rd_half;

    logic              b_rsp_valid_q;
    logic [LG-1:0]     b_lane_q;

    assign a_lane   = a_addr_i[LG-1:0];
    assign a_row    = a_addr_i[ADDR_W-1:LG];
    assign b_lane   = b_addr_i[LG-1:0];
    assign b_row    = b_addr_i[ADDR_W-1:LG];
    assign a_accept = a_req_valid_i & a_req_ready_o;

    // Response FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Response FSM next state: at most one outstanding response
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (a_accept) state_d = ST_RESP;
            ST_RESP: if (a_rsp_ready_i) state_d = a_accept ? ST_RESP : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response FSM outputs: ready whenever the response slot is free or being drained
    always_comb begin
        a_rsp_valid_o = (state_q == ST_RESP);
        a_req_ready_o = (state_q == ST_IDLE) | a_rsp_ready_i;
    end

    // Steer port A halfwords to banks; the lowest address is the word MSB half and a
    // word starting mid-row spills into the next row (wrapping at the top) for low banks
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            a_wh[j] = a_wdata_i[DATA_W-1-16*j -: 16];
        end
        for (int i = 0; i < LANES; i++) begin
            a_hsel[i]  = LG'(i) - a_lane;
            a_wd_b[i]  = a_half_i ? a_wdata_i[15:0] : a_wh[a_hsel[i]];
            a_row_b[i] = (!a_half_i && (LG'(i) < a_lane)) ? a_row + RW'(1) : a_row;
            a_we_b[i]  = a_accept & a_we_i & (~a_half_i | (a_lane == LG'(i)));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_bank
            logic [15:0] mem [ROWS];
            logic [15:0] dout_a_q;
            logic [15:0] dout_b_q;
            logic        b_hit;

`ifdef RDW_BYPASS_EN
            assign b_hit = a_we_b[gi] && (a_row_b[gi] == b_row);
`else
            assign b_hit = 1'b0;
`endif

            // Bank RAM: port A write/read-first read, port B read (optionally forwarded)
            always_ff @(posedge clk) begin
                if (a_we_b[gi]) mem[a_row_b[gi]] <= a_wd_b[gi];
                if (a_accept) dout_a_q <= mem[a_row_b[gi]];
                if (b_req_valid_i) dout_b_q <= b_hit ? a_wd_b[gi] : mem[b_row];
            end

            assign a_dout_w[gi] = dout_a_q;
            assign b_dout_w[gi] = dout_b_q;
        end
    endgenerate

    // Capture the access type of an accepted request for response formatting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            half_q  <= 1'b0;
            sext_q  <= 1'b0;
            lane_q  <= '0;
            first_q <= 1'b0;
        end else begin
            first_q <= a_accept;
            if (a_accept) begin
                we_q   <= a_we_i;
                half_q <= a_half_i;
                sext_q <= a_sext_i;
                lane_q <= a_lane;
            end
        end
    end

    // Un-rotate bank outputs into a big-endian word and apply halfword extension
    always_comb begin
        rd_word = '0;
        for (int j = 0; j < LANES; j++) begin
            rd_word[DATA_W-1-16*j -: 16] = a_dout_w[lane_q + LG'(j)];
        end
        rd_half = a_dout_w[lane_q];
        if (we_q)        fmt = '0;
        else if (half_q) fmt = {{(DATA_W-16){sext_q & rd_half[15]}}, rd_half};
        else             fmt = rd_word;
    end

    // Hold register keeps load data stable while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       hold_q <= '0;
        else if (first_q) hold_q <= fmt;
    end

    assign a_rdata_o = (state_q == ST_RESP) ? (first_q ? fmt : hold_q) : '0;

    // Port B fixed one-cycle fetch pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rsp_valid_q <= 1'b0;
            b_lane_q      <= '0;
        end else begin
            b_rsp_valid_q <= b_req_valid_i;
            if (b_req_valid_i) b_lane_q <= b_lane;
        end
    end

    assign b_rsp_valid_o = b_rsp_valid_q;
    assign b_rdata_o     = b_rsp_valid_q ? b_dout_w[b_lane_q] : 16'h0;

endmodule
